// File: rtl/crc_d24_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : crc_d24_packer_if
//  Description : Byte-stream input and packed CRC-word / tail / status outputs
//                of the 24-bit CRC byte packer.
//  Revision    : 1.0  initial release
// ============================================================================
interface crc_d24_packer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_eof;
    logic        in_ready;
    logic        crc_init;
    logic        crc_en;
    logic [23:0] crc_data;
    logic        tail_valid;
    logic [1:0]  tail_cnt;
    logic [15:0] tail_data;
    logic        frame_done;
    logic [15:0] frame_len;
    logic        err_abort;
    logic [7:0]  drop_cnt;

    // Byte source / result sink side
    modport master (
        output in_data, in_valid, in_sof, in_eof,
        input  in_ready, crc_init, crc_en, crc_data, tail_valid, tail_cnt,
               tail_data, frame_done, frame_len, err_abort, drop_cnt
    );

    // Packer side
    modport slave (
        input  in_data, in_valid, in_sof, in_eof,
        output in_ready, crc_init, crc_en, crc_data, tail_valid, tail_cnt,
               tail_data, frame_done, frame_len, err_abort, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/crc_d24_packer.sv
`default_nettype none
// ============================================================================
//  Module      : crc_d24_packer
//  Description : Packs framed bytes into 24-bit words for a 24-bit-wide CRC
//                stage, reports residual tail bytes, frame length, aborts and
//                bytes dropped outside a frame. All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module crc_d24_packer (
    input  wire             clk,
    input  wire             rst_n,
    crc_d24_packer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  phase, phase_nxt;          // bytes held in the partial word
    logic [15:0] part, part_nxt;            // lanes 0 and 1 of the partial word

    logic        accept;
    logic        start;
    logic [15:0] len_inc;
    logic [7:0]  drop_inc;

    logic        crc_init_nxt, crc_en_nxt, tail_valid_nxt;
    logic        frame_done_nxt, err_abort_nxt, in_ready_nxt;
    logic [23:0] crc_data_nxt;
    logic [1:0]  tail_cnt_nxt;
    logic [15:0] tail_data_nxt, len_nxt;
    logic [7:0]  drop_nxt;

    assign accept   = bus.in_valid & bus.in_ready;
    assign len_inc  = (bus.frame_len == 16'hFFFF) ? 16'hFFFF : bus.frame_len + 16'd1;
    assign drop_inc = (bus.drop_cnt == 8'hFF) ? 8'hFF : bus.drop_cnt + 8'd1;

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_nxt      = state;
        phase_nxt      = phase;
        part_nxt       = part;
        crc_data_nxt   = bus.crc_data;
        len_nxt        = bus.frame_len;
        drop_nxt       = bus.drop_cnt;
        crc_init_nxt   = 1'b0;
        crc_en_nxt     = 1'b0;
        tail_valid_nxt = 1'b0;
        tail_cnt_nxt   = 2'd0;
        tail_data_nxt  = 16'd0;
        frame_done_nxt = 1'b0;
        err_abort_nxt  = 1'b0;
        start          = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bus.in_sof) begin
                        start = 1'b1;
                    end else begin
                        drop_nxt = drop_inc;
                    end
                end
            end
            S_FILL: begin
                if (accept) begin
                    if (bus.in_sof) begin
                        // A new sof inside a frame throws away the partial word
                        start         = 1'b1;
                        err_abort_nxt = 1'b1;
                    end else begin
                        len_nxt = len_inc;
                        case (phase)
                            2'd0: begin
                                part_nxt[7:0] = bus.in_data;
                                phase_nxt     = 2'd1;
                            end
                            2'd1: begin
                                part_nxt[15:8] = bus.in_data;
                                phase_nxt      = 2'd2;
                            end
                            default: begin
                                crc_data_nxt = {bus.in_data, part};
                                crc_en_nxt   = 1'b1;
                                phase_nxt    = 2'd0;
                            end
                        endcase
                        if (bus.in_eof) begin
                            frame_done_nxt = 1'b1;
                            state_nxt      = S_GAP;
                            phase_nxt      = 2'd0;
                            part_nxt       = 16'd0;
                            if (phase == 2'd0) begin
                                tail_valid_nxt = 1'b1;
                                tail_cnt_nxt   = 2'd1;
                                tail_data_nxt  = {8'h00, bus.in_data};
                            end else if (phase == 2'd1) begin
                                tail_valid_nxt = 1'b1;
                                tail_cnt_nxt   = 2'd2;
                                tail_data_nxt  = {bus.in_data, part[7:0]};
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Frame start, shared by the IDLE entry and the abort-restart path
        if (start) begin
            crc_init_nxt = 1'b1;
            len_nxt      = 16'd1;
            part_nxt     = {8'h00, bus.in_data};
            phase_nxt    = 2'd1;
            state_nxt    = S_FILL;
            if (bus.in_eof) begin
                tail_valid_nxt = 1'b1;
                tail_cnt_nxt   = 2'd1;
                tail_data_nxt  = {8'h00, bus.in_data};
                frame_done_nxt = 1'b1;
                state_nxt      = S_GAP;
                phase_nxt      = 2'd0;
                part_nxt       = 16'd0;
            end
        end
    end

    // in_ready reflects the state being entered so it is 0 exactly in GAP
    assign in_ready_nxt = (state_nxt != S_GAP);

    // State register and internal packing context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            phase <= 2'd0;
            part  <= 16'd0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            part  <= part_nxt;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.in_ready   <= 1'b0;
            bus.crc_init   <= 1'b0;
            bus.crc_en     <= 1'b0;
            bus.crc_data   <= 24'd0;
            bus.tail_valid <= 1'b0;
            bus.tail_cnt   <= 2'd0;
            bus.tail_data  <= 16'd0;
            bus.frame_done <= 1'b0;
            bus.frame_len  <= 16'd0;
            bus.err_abort  <= 1'b0;
            bus.drop_cnt   <= 8'd0;
        end else begin
            bus.in_ready   <= in_ready_nxt;
            bus.crc_init   <= crc_init_nxt;
            bus.crc_en     <= crc_en_nxt;
            bus.crc_data   <= crc_data_nxt;
            bus.tail_valid <= tail_valid_nxt;
            bus.tail_cnt   <= tail_cnt_nxt;
            bus.tail_data  <= tail_data_nxt;
            bus.frame_done <= frame_done_nxt;
            bus.frame_len  <= len_nxt;
            bus.err_abort  <= err_abort_nxt;
            bus.drop_cnt   <= drop_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_d24_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc_d24_packer
//  Description : Self-checking bench for crc_d24_packer: directed frames plus
//                random framed traffic compared to a frame-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_crc_d24_packer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crc_d24_packer_if bus ();

    crc_d24_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Event log filled by the monitor; tests look only at entries after a snapshot
    logic [23:0] q_word[$];
    logic [17:0] q_tail[$];          // {tail_cnt, tail_data}
    logic [17:0] q_done[$];          // {crc_en, tail_valid, frame_len}
    int n_init = 0, n_abort = 0, n_abort_init = 0, n_clash = 0;
    int sw, st, sd, si, sa, sai;

    // Record output events away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.crc_en) q_word.push_back(bus.crc_data);
            if (bus.crc_init) n_init++;
            if (bus.err_abort) begin
                n_abort++;
                if (bus.crc_init) n_abort_init++;
            end
            if (bus.crc_init && bus.crc_en) n_clash++;
            if (bus.tail_valid) q_tail.push_back({bus.tail_cnt, bus.tail_data});
            if (bus.frame_done) q_done.push_back({bus.crc_en, bus.tail_valid, bus.frame_len});
        end
    end

    // Expected events from the frame-level model
    logic [23:0] ew[$];
    logic [17:0] et[$];
    logic [17:0] ed[$];

    task automatic snap();
        sw = q_word.size(); st = q_tail.size(); sd = q_done.size();
        si = n_init; sa = n_abort; sai = n_abort_init;
        ew.delete(); et.delete(); ed.delete();
    endtask

    // Model: whole 3-byte groups become words, the remainder becomes the tail
    task automatic model_frame(input logic [7:0] fb[$]);
        int len;
        int r;
        len = fb.size();
        for (int g = 0; g + 2 < len; g += 3)
            ew.push_back({fb[g+2], fb[g+1], fb[g]});
        r = len % 3;
        if (r == 1) et.push_back({2'd1, 8'h00, fb[len-1]});
        if (r == 2) et.push_back({2'd2, fb[len-1], fb[len-2]});
        ed.push_back({(r == 0), (r != 0), 16'(len)});
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_data = d; bus.in_valid = 1'b1; bus.in_sof = s; bus.in_eof = e;
        while (!bus.in_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) begin
            checks++; failures++;
            $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.crc_data !== 24'd0) begin failures++; $display("FAIL rst_crc_data got=%h exp=0", bus.crc_data); end
        checks++; if (bus.tail_data !== 16'd0 || bus.tail_cnt !== 2'd0) begin failures++; $display("FAIL rst_tail got=%h/%0d exp=0/0", bus.tail_data, bus.tail_cnt); end
        checks++; if (bus.frame_len !== 16'd0 || bus.drop_cnt !== 8'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", bus.frame_len, bus.drop_cnt); end
        checks++;
        if ({bus.crc_init, bus.crc_en, bus.tail_valid, bus.frame_done, bus.err_abort} !== 5'b0) begin
            failures++; $display("FAIL rst_pulses got=%b exp=00000",
                {bus.crc_init, bus.crc_en, bus.tail_valid, bus.frame_done, bus.err_abort});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_frame6();
        snap();
        for (int i = 1; i <= 6; i++) send(8'(i), (i == 1), (i == 6));
        idle(3);
        checks++; if (n_init - si !== 1) begin failures++; $display("FAIL f6_init got=%0d exp=1", n_init - si); end
        checks++; if (q_word.size() - sw !== 2) begin failures++; $display("FAIL f6_nwords got=%0d exp=2", q_word.size() - sw); end
        else begin
            checks++; if (q_word[sw] !== 24'h030201) begin failures++; $display("FAIL f6_word0 got=%h exp=030201", q_word[sw]); end
            checks++; if (q_word[sw+1] !== 24'h060504) begin failures++; $display("FAIL f6_word1 got=%h exp=060504", q_word[sw+1]); end
        end
        checks++; if (q_done.size() - sd !== 1) begin failures++; $display("FAIL f6_ndone got=%0d exp=1", q_done.size() - sd); end
        else begin
            checks++; if (q_done[sd] !== {1'b1, 1'b0, 16'd6}) begin failures++; $display("FAIL f6_done got=%h exp=%h", q_done[sd], {1'b1, 1'b0, 16'd6}); end
        end
        checks++; if (q_tail.size() !== st) begin failures++; $display("FAIL f6_tail got=%0d exp=0", q_tail.size() - st); end
    endtask

    task automatic test_frame5();
        logic [7:0] b[5];
        b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        snap();
        for (int i = 0; i < 5; i++) send(b[i], (i == 0), (i == 4));
        idle(3);
        checks++; if (q_word.size() - sw !== 1) begin failures++; $display("FAIL f5_nwords got=%0d exp=1", q_word.size() - sw); end
        else begin
            checks++; if (q_word[sw] !== 24'hCCBBAA) begin failures++; $display("FAIL f5_word got=%h exp=ccbbaa", q_word[sw]); end
        end
        checks++; if (q_tail.size() - st !== 1) begin failures++; $display("FAIL f5_ntail got=%0d exp=1", q_tail.size() - st); end
        else begin
            checks++; if (q_tail[st] !== {2'd2, 16'hEEDD}) begin failures++; $display("FAIL f5_tail got=%h exp=%h", q_tail[st], {2'd2, 16'hEEDD}); end
        end
        checks++; if (q_done.size() - sd !== 1) begin failures++; $display("FAIL f5_ndone got=%0d exp=1", q_done.size() - sd); end
        else begin
            checks++; if (q_done[sd] !== {1'b0, 1'b1, 16'd5}) begin failures++; $display("FAIL f5_done got=%h exp=%h", q_done[sd], {1'b0, 1'b1, 16'd5}); end
        end
    endtask

    task automatic test_single();
        snap();
        send(8'h5A, 1'b1, 1'b1);
        idle(1);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL single_ready_gap got=%b exp=0", bus.in_ready); end
        checks++;
        if ({bus.crc_init, bus.tail_valid, bus.frame_done, bus.crc_en} !== 4'b1110) begin
            failures++; $display("FAIL single_pulses got=%b exp=1110",
                {bus.crc_init, bus.tail_valid, bus.frame_done, bus.crc_en});
        end
        checks++; if (bus.tail_cnt !== 2'd1 || bus.tail_data !== 16'h005A) begin failures++; $display("FAIL single_tail got=%0d/%h exp=1/005a", bus.tail_cnt, bus.tail_data); end
        checks++; if (bus.frame_len !== 16'd1) begin failures++; $display("FAIL single_len got=%0d exp=1", bus.frame_len); end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_back got=%b exp=1", bus.in_ready); end
        idle(2);
        checks++; if (q_word.size() !== sw) begin failures++; $display("FAIL single_no_crc_en got=%0d exp=0", q_word.size() - sw); end
    endtask

    task automatic test_abort();
        snap();
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b1);
        idle(3);
        checks++; if (n_abort - sa !== 1 || n_abort_init - sai !== 1) begin failures++; $display("FAIL abort_pulse got=%0d/%0d exp=1/1", n_abort - sa, n_abort_init - sai); end
        checks++; if (q_word.size() - sw !== 1) begin failures++; $display("FAIL abort_nwords got=%0d exp=1", q_word.size() - sw); end
        else begin
            checks++; if (q_word[sw] !== 24'h554433) begin failures++; $display("FAIL abort_word got=%h exp=554433", q_word[sw]); end
        end
        checks++; if (q_done.size() - sd !== 1) begin failures++; $display("FAIL abort_ndone got=%0d exp=1", q_done.size() - sd); end
        else begin
            checks++; if (q_done[sd] !== {1'b1, 1'b0, 16'd3}) begin failures++; $display("FAIL abort_done got=%h exp=%h", q_done[sd], {1'b1, 1'b0, 16'd3}); end
        end
    endtask

    task automatic test_drop();
        logic [7:0] fb[$];
        do_reset();
        for (int i = 0; i < 300; i++) send(8'($urandom), 1'b0, 1'b0);
        idle(2);
        checks++; if (bus.drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat got=%0d exp=255", bus.drop_cnt); end
        snap();
        for (int i = 0; i < 3; i++) fb.push_back(8'($urandom));
        model_frame(fb);
        for (int i = 0; i < 3; i++) send(fb[i], (i == 0), (i == 2));
        idle(3);
        checks++; if (q_word.size() - sw !== 1) begin failures++; $display("FAIL drop_frame_nwords got=%0d exp=1", q_word.size() - sw); end
        else begin
            checks++; if (q_word[sw] !== ew[0]) begin failures++; $display("FAIL drop_frame_word got=%h exp=%h", q_word[sw], ew[0]); end
        end
        checks++; if (q_done.size() - sd !== 1) begin failures++; $display("FAIL drop_frame_ndone got=%0d exp=1", q_done.size() - sd); end
        else begin
            checks++; if (q_done[sd] !== ed[0]) begin failures++; $display("FAIL drop_frame_done got=%h exp=%h", q_done[sd], ed[0]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] fb[$];
        snap();
        send(8'h77, 1'b1, 1'b0);
        send(8'h88, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready got=%b exp=0", bus.in_ready); end
        rst_n = 1'b1;
        idle(3);
        checks++; if (q_done.size() !== sd || n_abort !== sa) begin failures++; $display("FAIL rmid_no_done got=%0d/%0d exp=0/0", q_done.size() - sd, n_abort - sa); end
        checks++; if (bus.frame_len !== 16'd0) begin failures++; $display("FAIL rmid_len got=%0d exp=0", bus.frame_len); end
        fb = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 3; i++) send(fb[i], (i == 0), (i == 2));
        idle(3);
        checks++; if (q_word.size() - sw !== 1) begin failures++; $display("FAIL rmid_nwords got=%0d exp=1", q_word.size() - sw); end
        else begin
            checks++; if (q_word[sw] !== 24'h030201) begin failures++; $display("FAIL rmid_word got=%h exp=030201", q_word[sw]); end
        end
    endtask

    // Random frames; with gaps enabled also idle cycles inside frames and
    // stray bytes between frames, otherwise strictly back-to-back
    task automatic test_frames(input int nframes, input bit gaps);
        logic [7:0] fb[$];
        int len;
        int exp_drop;
        do_reset();
        snap();
        exp_drop = 0;
        for (int f = 0; f < nframes; f++) begin
            if (gaps) begin
                int ns;
                ns = $urandom_range(0, 2);
                for (int k = 0; k < ns; k++) begin
                    send(8'($urandom), 1'b0, 1'b0);
                    exp_drop++;
                end
            end
            fb.delete();
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
            model_frame(fb);
            for (int i = 0; i < len; i++) begin
                if (gaps && i > 0 && ($urandom % 3) == 0) idle($urandom_range(1, 4));
                send(fb[i], (i == 0), (i == len - 1));
            end
        end
        idle(4);
        checks++; if (n_init - si !== nframes) begin failures++; $display("FAIL frames_init got=%0d exp=%0d", n_init - si, nframes); end
        checks++; if (n_clash !== 0) begin failures++; $display("FAIL frames_init_en_clash got=%0d exp=0", n_clash); end
        checks++; if (bus.drop_cnt !== 8'(exp_drop)) begin failures++; $display("FAIL frames_drop got=%0d exp=%0d", bus.drop_cnt, exp_drop); end
        checks++;
        if (q_word.size() - sw !== ew.size()) begin
            failures++; $display("FAIL frames_nwords got=%0d exp=%0d", q_word.size() - sw, ew.size());
        end else begin
            for (int i = 0; i < ew.size(); i++) begin
                checks++; if (q_word[sw+i] !== ew[i]) begin failures++; $display("FAIL frames_word[%0d] got=%h exp=%h", i, q_word[sw+i], ew[i]); end
            end
        end
        checks++;
        if (q_tail.size() - st !== et.size()) begin
            failures++; $display("FAIL frames_ntail got=%0d exp=%0d", q_tail.size() - st, et.size());
        end else begin
            for (int i = 0; i < et.size(); i++) begin
                checks++; if (q_tail[st+i] !== et[i]) begin failures++; $display("FAIL frames_tail[%0d] got=%h exp=%h", i, q_tail[st+i], et[i]); end
            end
        end
        checks++;
        if (q_done.size() - sd !== ed.size()) begin
            failures++; $display("FAIL frames_ndone got=%0d exp=%0d", q_done.size() - sd, ed.size());
        end else begin
            for (int i = 0; i < ed.size(); i++) begin
                checks++; if (q_done[sd+i] !== ed[i]) begin failures++; $display("FAIL frames_done[%0d] got=%h exp=%h", i, q_done[sd+i], ed[i]); end
            end
        end
    endtask

    initial begin
        bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
        test_reset();
        test_frame6();
        test_frame5();
        test_single();
        test_abort();
        test_drop();
        test_reset_mid();
        test_frames(6, 1'b0);
        test_frames(14, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crc_d24_packer.md
CRC_D24_PACKER -- requirements
Module: crc_d24_packer

Interface
REQ-001 SHALL have no parameters; widths are fixed: byte input 8 bits, CRC word 24 bits, length counter 16 bits.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst_n  in  1  async active-low reset
- in_data  in  8  payload byte
- in_valid  in  1  byte present
- in_sof  in  1  first byte of frame (qualified by in_valid)
- in_eof  in  1  last byte of frame (qualified by in_valid)
- in_ready  out  1  byte accepted when in_valid&in_ready
- crc_init  out  1  1-cycle pulse; synchronous restart of the 24-bit CRC stage
- crc_en  out  1  crc_data valid for the 24-bit CRC stage
- crc_data  out  24  packed word
- tail_valid  out  1  1-cycle pulse; residual bytes present
- tail_cnt  out  2  residual byte count 0..2
- tail_data  out  16  residual bytes, first byte in [7:0]
- frame_done  out  1  1-cycle pulse at end of frame
- frame_len  out  16  frame byte count, valid with frame_done
- err_abort  out  1  1-cycle pulse; frame aborted by new in_sof
- drop_cnt  out  8  saturating count of bytes dropped outside a frame

Function
REQ-004 SHALL implement states IDLE, FILL, GAP.
REQ-005 An accepted byte SHALL be in_valid&in_ready; in_ready SHALL be 1 in IDLE and FILL, 0 in GAP.
REQ-006 In IDLE, a byte without in_sof SHALL be discarded and drop_cnt incremented, saturating at 255.
REQ-007 In IDLE, a byte with in_sof SHALL start a frame: phase=1, byte held in lane 0, length=1, state->FILL; crc_init SHALL pulse the following cycle.
REQ-008 Byte lanes: the k-th byte of a 3-byte group (k=0,1,2) SHALL occupy crc_data[8k+7:8k].
REQ-009 When the third byte of a group is accepted, crc_en SHALL be 1 for exactly one cycle on the next cycle with the completed word; latency 1 cycle.
REQ-010 crc_data SHALL hold its last value when crc_en=0; crc_init SHALL never coincide with crc_en.
REQ-011 frame_len SHALL count accepted frame bytes including sof and eof bytes, saturating at 65535.
REQ-012 On an eof byte accepted at phase 2 (third lane), the next cycle SHALL show crc_en=1, frame_done=1, tail_cnt=0, tail_valid=0.
REQ-013 On an eof byte at lane 0 or 1, the next cycle SHALL show tail_valid=1, tail_cnt=1 or 2, tail_data with unused bits 0, frame_done=1, crc_en=0.
REQ-014 After any eof acceptance, state SHALL go to GAP for exactly one cycle, then IDLE.
REQ-015 A byte with in_sof and in_eof together in IDLE SHALL be a 1-byte frame: crc_init and tail_valid(tail_cnt=1) and frame_done all pulse on the next cycle.
REQ-016 A byte with in_sof in FILL SHALL abort: the partial word is discarded, err_abort pulses next cycle together with crc_init, and the byte starts a new frame at lane 0 with frame_len=1.
REQ-017 in_valid=0 in FILL SHALL hold phase and partial word indefinitely; there is no timeout.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 While rst_n=0: state=IDLE, phase=0, crc_data=0, tail_data=0, tail_cnt=0, frame_len=0, drop_cnt=0, and all pulses=0; in_ready SHALL be 0 during reset and 1 from the first clock edge after release.
REQ-020 Reset asserted mid-frame SHALL discard the frame with no frame_done or err_abort.

Verification
REQ-021 Frame bytes 01..06 (sof on 01, eof on 06): crc_init once, then crc_en with 0x030201, then crc_en with 0x060504 plus frame_done, frame_len=6, tail_valid=0.
REQ-022 Frame bytes AA,BB,CC,DD,EE (eof on EE): crc_en with 0xCCBBAA, then tail_valid with tail_cnt=2, tail_data=0xEEDD, frame_done, frame_len=5.
REQ-023 Single byte 5A with sof and eof: crc_init, tail_cnt=1, tail_data=0x005A, frame_done, frame_len=1; no crc_en; in_ready=0 for one cycle.
REQ-024 sof 11,22 then sof 33,44,55 with eof on 55: err_abort once, then crc_en with 0x554433, frame_len=3; 11 and 22 never appear on crc_data.
REQ-025 300 bytes without sof in IDLE: drop_cnt=255; then a valid 3-byte frame is processed normally.
REQ-026 Random in_valid gaps within a 3-byte frame: crc_en word is identical to the gap-free case; rst_n pulsed mid-frame yields no frame_done.
